botun_game_ctrl: RTL and testbench
==================================

BOTUN_GAME_CTRL -- requirements
Module: botun_game_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, giving clock cycles per one-second tick.
REQ-002 SHALL have parameter DEB_CYCLES, default 250000, giving the number of stable cycles required before a debounced level changes.
REQ-003 SHALL have parameter ROUND_SECS, default 9, giving the countdown start value per round.
REQ-004 SHALL have ports clk, in, 1, sole clock; and rst, in, 1, synchronous active-high reset.
REQ-005 SHALL have port key, in, 4, raw asynchronous push-buttons (key[0] = button 1).
REQ-006 SHALL have port target, out, 2, current button to press (0..3), consumed by the text stage.
REQ-007 SHALL have port score, out, 4, correct hits 0..9.
REQ-008 SHALL have port lives, out, 2, remaining lives 0..3.
REQ-009 SHALL have port secs_left, out, 4, countdown value ROUND_SECS..0.
REQ-010 SHALL have port game_over, out, 1, high in state OVER.
REQ-011 SHALL have port win, out, 1, high in OVER when score = 9.

Function
REQ-012 SHALL pass each key through a 2-flop synchronizer, then a debouncer that changes its level only after DEB_CYCLES consecutive equal samples.
REQ-013 SHALL emit a one-cycle press pulse on each debounced 0->1 edge; release edges are ignored.
REQ-014 SHALL implement FSM states IDLE, ROUND, OVER.
REQ-015 In IDLE, any press pulse SHALL go to ROUND with score=0, lives=3, secs_left=ROUND_SECS and a new target.
REQ-016 SHALL generate a 1-second tick from a counter that wraps at CLK_HZ-1; the counter is cleared on every round start.
REQ-017 In ROUND, each tick SHALL decrement secs_left; a tick while secs_left=0 is a miss.
REQ-018 In ROUND, a single press pulse on key[target] SHALL be a hit: score+1, new target, secs_left reload.
REQ-019 In ROUND, a press on any other key, or pulses on two or more keys in the same cycle, SHALL be one miss.
REQ-020 A miss SHALL do: lives-1, new target, secs_left reload.
REQ-021 A press and a timeout in the same cycle SHALL evaluate the press only.
REQ-022 A hit making score=9 SHALL go to OVER with win=1.
REQ-023 A miss making lives=0 SHALL go to OVER with win=0.
REQ-024 Score and lives SHALL saturate and never wrap.
REQ-025 In OVER, all outputs SHALL hold; any press pulse goes to IDLE.
REQ-026 The new target SHALL be taken from an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, free-running, bits [1:0]); if it equals the previous target, (value+1) mod 4 is used.
REQ-027 All outputs SHALL be registered and update on the cycle after the press pulse or tick.

Reset
REQ-028 On rst: state=IDLE, target=0, score=0, lives=3, secs_left=ROUND_SECS, game_over=0, win=0.
REQ-029 On rst: tick counter=0, debounced levels=0, synchronizers=0, LFSR=8'h01.
REQ-030 Reset mid-round SHALL abort with no press pulse generated, even if a key is held through reset release.

Structure
REQ-031 Package botun_pkg SHALL hold the state enum, MAX_SCORE=9, START_LIVES=3 and the LFSR tap constant.
REQ-032 Sub-module botun_debounce (synchronizer + debouncer + edge pulse) SHALL be instantiated four times.

Verification (CLK_HZ=20, DEB_CYCLES=4, ROUND_SECS=3)
REQ-033 Bounce: key[1] toggles every 2 cycles for 10 cycles, then holds high for 6 cycles -> exactly one press pulse, 6 cycles (2 sync + 4 stable) after the last edge.
REQ-034 Start and hit: press from IDLE -> ROUND, score 0, lives 3; press key[target] -> score 1, target changes, secs_left=3.
REQ-035 Timeout: no press for 4 ticks (80 cycles) -> lives 2, secs_left reloads to 3.
REQ-036 Multi-press: pulses on key[0] and key[2] in the same cycle -> lives drops by exactly 1, score unchanged.
REQ-037 Endgame: 9 hits -> game_over=1, win=1, outputs frozen, next press -> IDLE; 3 misses -> game_over=1, win=0.
REQ-038 Reset: rst asserted mid-round with key[3] held -> all REQ-028 values, and no press pulse after release until key[3] is released and pressed again.

Source files
------------

// File: rtl/botun_pkg.sv
// Shared types and constants for the four-button reaction game.
package botun_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, OVER} state_t;

  localparam int         NUM_KEYS    = 4;
  localparam int         SYNC_STAGES = 2;
  localparam logic [3:0] MAX_SCORE   = 4'd9;
  localparam logic [1:0] START_LIVES = 2'd3;
  localparam logic [7:0] LFSR_SEED   = 8'h01;
  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Never repeat the previous target back to back.
  function automatic logic [1:0] next_target(input logic [7:0] s, input logic [1:0] prev);
    return (s[1:0] == prev) ? s[1:0] + 2'd1 : s[1:0];
  endfunction

endpackage

// File: rtl/botun_debounce.sv
// One push-button: 2-flop synchronizer, counting debouncer, rising-edge press pulse.
module botun_debounce
  import botun_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   lvl;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic                   smp;

  assign smp = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      vld_pipe <= '0;
      lvl      <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], key};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      press    <= 1'b0;
      // A key held through reset must be seen released before it can fire.
      if (vld_pipe[SYNC_STAGES-1] && !smp)
        armed <= 1'b1;
      if (smp == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        lvl   <= smp;
        cnt   <= '0;
        press <= smp & armed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/botun_game_ctrl.sv
// Game controller: press the lit button before the countdown expires; 9 hits win, 3 misses lose.
module botun_game_ctrl
  import botun_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int DEB_CYCLES = 250000,
  parameter int ROUND_SECS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [1:0] target,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [3:0] secs_left,
  output logic       game_over,
  output logic       win
);

  localparam int         TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [3:0] SECS_INIT = 4'(ROUND_SECS);

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] press_m1;
  logic                any_press;
  logic                multi;
  logic                hit;
  logic                miss;
  logic                tick;
  logic                start;
  logic [TW-1:0]       tick_cnt;
  logic [7:0]          lfsr;
  logic [1:0]          new_target;
  state_t              state;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    botun_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key   (key[i]),
      .press (press[i])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more keys fired.
  assign press_m1   = press - NUM_KEYS'(1);
  assign any_press  = |press;
  assign multi      = |(press & press_m1);
  assign hit        = any_press && !multi && press[target];
  assign tick       = (tick_cnt == TW'(CLK_HZ - 1));
  assign miss       = (any_press && !hit) || (!any_press && tick && secs_left == 4'd0);
  assign start      = (state == IDLE) && any_press;
  assign new_target = next_target(lfsr, target);

  always_ff @(posedge clk) begin
    if (rst || start || tick) tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= 2'd0;
      score     <= 4'd0;
      lives     <= START_LIVES;
      secs_left <= SECS_INIT;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_press) begin
            state     <= ROUND;
            score     <= 4'd0;
            lives     <= START_LIVES;
            secs_left <= SECS_INIT;
            target    <= new_target;
          end
        end
        ROUND: begin
          if (hit) begin
            target    <= new_target;
            secs_left <= SECS_INIT;
            if (score != MAX_SCORE) score <= score + 4'd1;
            if (score == MAX_SCORE - 4'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
              win       <= 1'b1;
            end
          end else if (miss) begin
            target    <= new_target;
            secs_left <= SECS_INIT;
            if (lives != 2'd0) lives <= lives - 2'd1;
            if (lives <= 2'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
              win       <= 1'b0;
            end
          end else if (tick) begin
            secs_left <= secs_left - 4'd1;
          end
        end
        OVER: begin
          if (any_press) begin
            state     <= IDLE;
            game_over <= 1'b0;
            win       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_botun_game_ctrl.sv
// Directed plus randomized checks of botun_game_ctrl against a cycle-level game model.
module tb_botun_game_ctrl;

  localparam int CLK_HZ = 20;
  localparam int DEB    = 4;
  localparam int RS     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'd0;
  logic [1:0] target, lives;
  logic [3:0] score, secs_left;
  logic       game_over, win;

  botun_game_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB), .ROUND_SECS(RS)) dut (
    .clk(clk), .rst(rst), .key(key), .target(target), .score(score),
    .lives(lives), .secs_left(secs_left), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state: game rules as plain arithmetic, buttons as sample histories.
  int         m_state;  // 0 waiting, 1 playing, 2 finished
  int         m_since;
  logic [1:0] m_target, m_lives;
  logic [3:0] m_score, m_secs;
  logic       m_over, m_win;
  logic [7:0] m_lfsr;
  logic [3:0] m_press, m_lvl, m_val, m_armed;
  logic [1:0] m_dly [4];
  int         m_run [4];
  int         m_vld;

  function automatic logic [1:0] pick(input logic [7:0] l, input logic [1:0] prev);
    logic [1:0] c;
    c = l[1:0];
    return (c == prev) ? c + 2'd1 : c;
  endfunction

  always @(posedge clk) begin : ref_model
    logic [3:0] p, np;
    logic s2, tk;
    if (rst) begin
      m_state = 0; m_since = 0; m_target = 0; m_lives = 3; m_score = 0; m_secs = RS;
      m_over = 0; m_win = 0; m_lfsr = 8'h01; m_press = 0; m_lvl = 0; m_val = 0;
      m_armed = 0; m_vld = 0;
      for (int k = 0; k < 4; k++) begin m_dly[k] = 2'b00; m_run[k] = 0; end
    end else begin
      p = m_press;
      case (m_state)
        0: if (p != 0) begin
          m_state = 1; m_score = 0; m_lives = 3; m_secs = RS; m_since = 0;
          m_target = pick(m_lfsr, m_target);
        end
        1: begin
          m_since++;
          tk = ((m_since % CLK_HZ) == 0);
          if (p != 0 && $countones(p) == 1 && p[m_target]) begin
            if (m_score < 9) m_score = m_score + 1;
            m_target = pick(m_lfsr, m_target); m_secs = RS;
            if (m_score == 9) begin m_state = 2; m_over = 1; m_win = 1; end
          end else if (p != 0 || (tk && m_secs == 0)) begin
            if (m_lives > 0) m_lives = m_lives - 1;
            m_target = pick(m_lfsr, m_target); m_secs = RS;
            if (m_lives == 0) begin m_state = 2; m_over = 1; m_win = 0; end
          end else if (tk) begin
            m_secs = m_secs - 1;
          end
        end
        default: if (p != 0) begin m_state = 0; m_over = 0; m_win = 0; end
      endcase
      np = 4'd0;
      for (int k = 0; k < 4; k++) begin
        s2 = m_dly[k][1];
        if (m_vld >= 2 && !s2) m_armed[k] = 1'b1;
        if (s2 == m_val[k]) m_run[k]++;
        else begin m_val[k] = s2; m_run[k] = 1; end
        if (m_run[k] >= DEB && s2 != m_lvl[k]) begin
          m_lvl[k] = s2;
          np[k] = s2 & m_armed[k];
        end
        m_dly[k] = {m_dly[k][0], key[k]};
      end
      m_press = np;
      if (m_vld < 2) m_vld++;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    chk("target",    8'(target),    8'(m_target));
    chk("score",     8'(score),     8'(m_score));
    chk("lives",     8'(lives),     8'(m_lives));
    chk("secs_left", 8'(secs_left), 8'(m_secs));
    chk("game_over", 8'(game_over), 8'(m_over));
    chk("win",       8'(win),       8'(m_win));
    chk("press",     8'(dut.press), 8'(m_press));
  endtask

  logic [3:0] snap_secs;
  logic [1:0] snap_target;

  task automatic press_key(input int k);
    key[k] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin snap_secs = secs_left; snap_target = target; end
    end
    key[k] = 1'b0;
    repeat (8) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_target"}, 8'(target), 8'd0);
    chk({tag, "_score"},  8'(score),  8'd0);
    chk({tag, "_lives"},  8'(lives),  8'd3);
    chk({tag, "_secs"},   8'(secs_left), 8'd3);
    chk({tag, "_over"},   8'(game_over), 8'd0);
    chk({tag, "_win"},    8'(win),    8'd0);
  endtask

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int np, lat, n;
    logic [1:0] t0, sl;
    logic [3:0] ss;

    rst = 1'b1;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) step();

    // Bouncing key[1]: only the final stable high may produce a pulse.
    np = 0; lat = -1;
    for (int i = 0; i < 4; i++) begin
      key[1] = ~key[1];
      repeat (2) begin step(); if (dut.press[1]) np++; end
    end
    key[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (dut.press[1]) begin np++; lat = i; end
    end
    chk("bounce_pulses", 8'(np), 8'd1);
    chk("bounce_latency", 8'(lat), 8'd6);
    chk("start_score", 8'(score), 8'd0);
    chk("start_lives", 8'(lives), 8'd3);
    key[1] = 1'b0;
    repeat (8) step();

    // Hit
    t0 = m_target;
    press_key(int'(t0));
    chk("hit_score", 8'(score), 8'd1);
    chk("hit_secs", 8'(snap_secs), 8'd3);
    chk("hit_target_moved", 8'(snap_target != t0), 8'd1);

    // Timeout miss
    n = 0;
    while (lives == 2'd3 && n < 100) begin step(); n++; end
    chk("timeout_lives", 8'(lives), 8'd2);
    chk("timeout_secs", 8'(secs_left), 8'd3);
    chk("timeout_in_budget", 8'(n > 0 && n <= 80), 8'd1);

    // Two keys in the same cycle
    sl = lives; ss = score;
    key = 4'b0101;
    repeat (8) step();
    key = 4'b0000;
    repeat (8) step();
    chk("multi_lives", 8'(lives), 8'(sl - 2'd1));
    chk("multi_score", 8'(score), 8'(ss));

    // Win
    rst = 1'b1; repeat (2) step(); rst = 1'b0; repeat (2) step();
    press_key(0);
    repeat (9) press_key(int'(m_target));
    chk("win_over", 8'(game_over), 8'd1);
    chk("win_win", 8'(win), 8'd1);
    chk("win_score", 8'(score), 8'd9);
    repeat (45) step();
    chk("frozen_score", 8'(score), 8'd9);
    chk("frozen_lives", 8'(lives), 8'd3);
    chk("frozen_secs", 8'(secs_left), 8'd3);
    chk("frozen_over", 8'(game_over), 8'd1);
    press_key(1);
    chk("idle_over", 8'(game_over), 8'd0);
    chk("idle_win", 8'(win), 8'd0);

    // Lose
    press_key(0);
    repeat (3) press_key(int'(m_target + 2'd1));
    chk("lose_over", 8'(game_over), 8'd1);
    chk("lose_win", 8'(win), 8'd0);
    chk("lose_lives", 8'(lives), 8'd0);

    // Reset mid-round with key[3] held
    press_key(1);
    press_key(2);
    key[3] = 1'b1;
    repeat (3) step();
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    chk_reset_vals("midrst");
    np = 0;
    repeat (20) begin step(); if (dut.press[3]) np++; end
    chk("held_no_pulse", 8'(np), 8'd0);
    key[3] = 1'b0;
    repeat (8) step();
    key[3] = 1'b1;
    np = 0;
    repeat (8) begin step(); if (dut.press[3]) np++; end
    chk("repress_pulse", 8'(np), 8'd1);
    key[3] = 1'b0;
    repeat (8) step();

    // Randomized play
    for (int it = 0; it < 90; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 2) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if (r < 5) key = 4'($urandom);
      else if (r < 12) key = 4'd1 << m_target;
      else key = 4'd1 << $urandom_range(0, 3);
      repeat ($urandom_range(1, 10)) step();
      key = 4'd0;
      repeat ($urandom_range(1, 12)) step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
